// File: rtl/hp_mul_iter_pkg.sv
// Shared bfloat16 definitions: class flag indices, exception indices,
// canonical encodings and the multiplier FSM state.
package hp_mul_iter_pkg;
    localparam int NEXP = 8;
    localparam int NSIG = 7;
    localparam int W    = NEXP + NSIG + 1;
    localparam int EW   = NEXP + 2;
    localparam int SW   = NSIG + 1;
    localparam int AW   = 2 * SW;
    localparam int CW   = $clog2(SW);
    localparam int SHW  = $clog2(SW);
    localparam int BIAS = 2 ** (NEXP - 1) - 1;

    localparam int SNAN      = 0;
    localparam int QNAN      = 1;
    localparam int INFINITY  = 2;
    localparam int ZERO      = 3;
    localparam int SUBNORMAL = 4;
    localparam int NORMAL    = 5;
    localparam int NTYPES    = 6;

    localparam int INVALID     = 0;
    localparam int DIVZERO     = 1;
    localparam int OVERFLOW    = 2;
    localparam int UNDERFLOW   = 3;
    localparam int INEXACT     = 4;
    localparam int NEXCEPTIONS = 5;

    localparam logic [NEXP-1:0] EXP_ONES   = '1;
    localparam logic [NEXP-1:0] EXP_ZERO   = '0;
    localparam logic [NSIG-1:0] FRAC_ZERO  = '0;
    localparam logic [W-1:0]    QNAN_CANON = {1'b0, EXP_ONES, 1'b1, {(NSIG - 1){1'b0}}};
    localparam logic signed [EW-1:0] E_INF  = EW'((2 ** NEXP) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/hp_class.sv
// Classifies one bfloat16 operand and returns its significand in 1.xxx form
// together with the left shift needed to get there (nonzero only for subnormals).
module hp_class
    import hp_mul_iter_pkg::*;
(
    input  logic [W-1:0]      i_f,
    output logic [NTYPES-1:0] o_flags,
    output logic [NSIG:0]     o_sig,
    output logic [SHW-1:0]    o_shift
);
    logic [NEXP-1:0] w_exp;
    logic [NSIG-1:0] w_frac;
    logic [SHW-1:0]  w_pos;

    assign w_exp  = i_f[W-2 -: NEXP];
    assign w_frac = i_f[NSIG-1:0];

    always_comb begin
        o_flags = '0;
        if (w_exp == EXP_ONES) begin
            if (w_frac == FRAC_ZERO)   o_flags[INFINITY] = 1'b1;
            else if (w_frac[NSIG-1])   o_flags[QNAN]     = 1'b1;
            else                       o_flags[SNAN]     = 1'b1;
        end else if (w_exp == EXP_ZERO) begin
            if (w_frac == FRAC_ZERO)   o_flags[ZERO]      = 1'b1;
            else                       o_flags[SUBNORMAL] = 1'b1;
        end else begin
            o_flags[NORMAL] = 1'b1;
        end
    end

    // Leading-one position of a subnormal fraction sets the normalising shift.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < NSIG; i++) begin
            if (w_frac[i]) w_pos = SHW'(i);
        end
        if (w_exp == EXP_ZERO) begin
            o_shift = SHW'(NSIG) - w_pos;
            o_sig   = {1'b0, w_frac} << o_shift;
        end else begin
            o_shift = '0;
            o_sig   = {1'b1, w_frac};
        end
    end
endmodule

// File: rtl/hp_mul_iter.sv
// Iterative bfloat16 multiplier: shift-and-add significand product, normalise,
// round-to-nearest-even, result held on a valid/ready output channel.
module hp_mul_iter
    import hp_mul_iter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           p,
    output logic [NTYPES-1:0]      bfFlags,
    output logic [NEXCEPTIONS-1:0] exception,
    output logic [2:0]             o_dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; the consumer of each channel may not infer anything from ready alone.
    state_t r_state, w_next;

    logic [NTYPES-1:0] w_fa, w_fb;
    logic [SW-1:0]     w_sig_a, w_sig_b;
    logic [SHW-1:0]    w_shift_a, w_shift_b;

    hp_class u_class_a (.i_f(a), .o_flags(w_fa), .o_sig(w_sig_a), .o_shift(w_shift_a));
    hp_class u_class_b (.i_f(b), .o_flags(w_fb), .o_sig(w_sig_b), .o_shift(w_shift_b));

    logic                   r_sign, r_out_valid, r_guard, r_sticky;
    logic [SW-1:0]          r_sig_a, r_sig_b, r_mant;
    logic signed [EW-1:0]   r_e;
    logic [AW-1:0]          r_acc;
    logic [CW-1:0]          r_cnt;
    logic [W-1:0]           r_p;
    logic [NTYPES-1:0]      r_flags;
    logic [NEXCEPTIONS-1:0] r_exc;

    logic                   w_sign_in, w_is_special;
    logic [NEXP-1:0]        w_expa, w_expb;
    logic signed [EW-1:0]   w_e_in;
    logic [W-1:0]           w_spec_p;
    logic [NTYPES-1:0]      w_spec_flags;
    logic [NEXCEPTIONS-1:0] w_spec_exc;

    assign w_sign_in = a[W-1] ^ b[W-1];
    assign w_expa    = w_fa[SUBNORMAL] ? NEXP'(1) : a[W-2 -: NEXP];
    assign w_expb    = w_fb[SUBNORMAL] ? NEXP'(1) : b[W-2 -: NEXP];
    assign w_e_in    = EW'(w_expa) + EW'(w_expb) - EW'(BIAS) - EW'(w_shift_a) - EW'(w_shift_b);
    assign w_is_special = !((w_fa[NORMAL] | w_fa[SUBNORMAL]) && (w_fb[NORMAL] | w_fb[SUBNORMAL]));

    always_comb begin
        w_spec_p     = '0;
        w_spec_flags = '0;
        w_spec_exc   = '0;
        if (w_fa[SNAN] | w_fa[QNAN] | w_fb[SNAN] | w_fb[QNAN]) begin
            w_spec_p            = QNAN_CANON;
            w_spec_flags[QNAN]  = 1'b1;
            w_spec_exc[INVALID] = w_fa[SNAN] | w_fb[SNAN];
        end else if ((w_fa[INFINITY] && w_fb[ZERO]) || (w_fa[ZERO] && w_fb[INFINITY])) begin
            w_spec_p            = QNAN_CANON;
            w_spec_flags[QNAN]  = 1'b1;
            w_spec_exc[INVALID] = 1'b1;
        end else if (w_fa[INFINITY] | w_fb[INFINITY]) begin
            w_spec_p               = {w_sign_in, EXP_ONES, FRAC_ZERO};
            w_spec_flags[INFINITY] = 1'b1;
        end else begin
            w_spec_p           = {w_sign_in, EXP_ZERO, FRAC_ZERO};
            w_spec_flags[ZERO] = 1'b1;
        end
    end

    logic [AW-1:0] w_partial;
    assign w_partial = r_sig_b[r_cnt] ? (AW'(r_sig_a) << r_cnt) : '0;

    // Product lies in [1,4): MSB set means the binary point moves up by one.
    logic          w_msb, w_norm_guard, w_norm_sticky;
    logic [SW-1:0] w_norm_mant;
    assign w_msb         = r_acc[AW-1];
    assign w_norm_mant   = w_msb ? r_acc[AW-1 -: SW] : r_acc[AW-2 -: SW];
    assign w_norm_guard  = w_msb ? r_acc[NSIG] : r_acc[NSIG-1];
    assign w_norm_sticky = w_msb ? |r_acc[NSIG-1:0] : |r_acc[NSIG-2:0];

    logic                   w_rnd_up, w_inexact;
    logic [SW:0]            w_mant_r;
    logic [NSIG-1:0]        w_frac_r;
    logic signed [EW-1:0]   w_e_r;
    logic [W-1:0]           w_rnd_p;
    logic [NTYPES-1:0]      w_rnd_flags;
    logic [NEXCEPTIONS-1:0] w_rnd_exc;

    assign w_rnd_up  = r_guard & (r_sticky | r_mant[0]);
    assign w_inexact = r_guard | r_sticky;
    assign w_mant_r  = {1'b0, r_mant} + (SW + 1)'(w_rnd_up);
    assign w_frac_r  = w_mant_r[SW] ? w_mant_r[NSIG:1] : w_mant_r[NSIG-1:0];
    assign w_e_r     = w_mant_r[SW] ? r_e + EW'(1) : r_e;

    always_comb begin
        w_rnd_p     = {r_sign, w_e_r[NEXP-1:0], w_frac_r};
        w_rnd_flags = '0;
        w_rnd_exc   = '0;
        if (w_e_r >= E_INF) begin
            w_rnd_p               = {r_sign, EXP_ONES, FRAC_ZERO};
            w_rnd_flags[INFINITY] = 1'b1;
            w_rnd_exc[OVERFLOW]   = 1'b1;
            w_rnd_exc[INEXACT]    = 1'b1;
        end else if (w_e_r <= E_ZERO) begin
            w_rnd_p              = {r_sign, EXP_ZERO, FRAC_ZERO};
            w_rnd_flags[ZERO]    = 1'b1;
            w_rnd_exc[UNDERFLOW] = 1'b1;
            w_rnd_exc[INEXACT]   = 1'b1;
        end else begin
            w_rnd_flags[NORMAL] = 1'b1;
            w_rnd_exc[INEXACT]  = w_inexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = w_is_special ? ST_DONE : ST_MUL;
            ST_MUL:   if (r_cnt == CW'(NSIG)) w_next = ST_NORM;
            ST_NORM:  w_next = ST_ROUND;
            ST_ROUND: w_next = ST_DONE;
            ST_DONE:  if (r_out_valid && out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == ST_IDLE);
        o_dbg_state = r_state;
        out_valid   = r_out_valid;
        p           = r_p;
        bfFlags     = r_flags;
        exception   = r_exc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign <= 1'b0; r_out_valid <= 1'b0; r_guard <= 1'b0; r_sticky <= 1'b0;
            r_sig_a <= '0; r_sig_b <= '0; r_mant <= '0; r_e <= '0;
            r_acc <= '0; r_cnt <= '0; r_p <= '0; r_flags <= '0; r_exc <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_sign  <= w_sign_in;
                    r_sig_a <= w_sig_a;
                    r_sig_b <= w_sig_b;
                    r_e     <= w_e_in;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    if (w_is_special) begin
                        r_p     <= w_spec_p;
                        r_flags <= w_spec_flags;
                        r_exc   <= w_spec_exc;
                    end
                end
                ST_MUL: begin
                    r_acc <= r_acc + w_partial;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_NORM: begin
                    r_mant   <= w_norm_mant;
                    r_guard  <= w_norm_guard;
                    r_sticky <= w_norm_sticky;
                    r_e      <= w_msb ? r_e + EW'(1) : r_e;
                end
                ST_ROUND: begin
                    r_p     <= w_rnd_p;
                    r_flags <= w_rnd_flags;
                    r_exc   <= w_rnd_exc;
                end
                ST_DONE: begin
                    if (!r_out_valid)   r_out_valid <= 1'b1;
                    else if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hp_mul_iter.sv
// Directed bench for hp_mul_iter: hand-computed bfloat16 products, latency,
// back-pressure hold and mid-operation reset.
module tb_hp_mul_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid;
  logic [15:0] p;
  logic [5:0]  bf_flags;
  logic [4:0]  exc;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] F_QNAN = 6'b000010;
  localparam logic [5:0] F_INF  = 6'b000100;
  localparam logic [5:0] F_ZERO = 6'b001000;
  localparam logic [5:0] F_NORM = 6'b100000;
  localparam logic [4:0] X_NONE = 5'b00000;
  localparam logic [4:0] X_INV  = 5'b00001;
  localparam logic [4:0] X_OVF  = 5'b00100;
  localparam logic [4:0] X_UNF  = 5'b01000;
  localparam logic [4:0] X_INX  = 5'b10000;

  always #5 clk = ~clk;

  hp_mul_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .bfFlags(bf_flags), .exception(exc), .o_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic [15:0] ep, input logic [5:0] ef, input logic [4:0] ee,
                        input int elat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    a = ta; b = tbv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " p"}, 32'(p), 32'(ep));
    check({tag, " flags"}, 32'(bf_flags), 32'(ef));
    check({tag, " exception"}, 32'(exc), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, {p, 13'b0, out_valid, in_ready, 1'b0}, {ep, 13'b0, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " released"}, {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int seen;
    #12;
    check("reset outputs", {8'b0, p, 1'b0, in_ready, out_valid, bf_flags, exc[3:0]}, {8'b0, 16'h0, 1'b0, 1'b1, 1'b0, 6'b0, 4'b0});
    check("reset exc_state", {27'b0, exc[4], dbg_state}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("1.5x2",      16'h3FC0, 16'h4000, 16'h4040, F_NORM, X_NONE, 11, 0);
    run_op("infx0",      16'h7F80, 16'h0000, 16'h7FC0, F_QNAN, X_INV,  1,  0);
    run_op("overflow",   16'h7F00, 16'h4000, 16'h7F80, F_INF,  X_OVF | X_INX, 11, 0);
    run_op("underflow",  16'h0080, 16'h3F00, 16'h0000, F_ZERO, X_UNF | X_INX, 11, 0);
    run_op("sticky",     16'h3F81, 16'h3F81, 16'h3F82, F_NORM, X_INX, 11, 0);
    run_op("tie_even",   16'h3F83, 16'h3FC0, 16'h3FC4, F_NORM, X_INX, 11, 0);
    run_op("tie_odd",    16'h3F85, 16'h3FC0, 16'h3FC8, F_NORM, X_INX, 11, 0);
    run_op("neg_sign",   16'hBFC0, 16'h4000, 16'hC040, F_NORM, X_NONE, 11, 0);
    run_op("subnormal",  16'h0040, 16'h4300, 16'h0380, F_NORM, X_NONE, 11, 0);
    run_op("snan",       16'h7F81, 16'h3F80, 16'h7FC0, F_QNAN, X_INV,  1,  0);
    run_op("qnan",       16'hFFC0, 16'h3F80, 16'h7FC0, F_QNAN, X_NONE, 1,  0);
    run_op("neg_zero",   16'h8000, 16'h3F80, 16'h8000, F_ZERO, X_NONE, 1,  0);
    run_op("inf_neg",    16'h7F80, 16'hC000, 16'hFF80, F_INF,  X_NONE, 1,  0);
    run_op("backpress",  16'h3FC0, 16'h4000, 16'h4040, F_NORM, X_NONE, 11, 5);

    // Reset in the middle of the MUL loop discards the operation.
    @(negedge clk);
    a = 16'h3FC0; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid state is MUL", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset in_ready/out_valid/p", {14'b0, in_ready, out_valid, p}, {14'b0, 1'b1, 1'b0, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("no stale result", 32'(seen), 32'd0);
    run_op("after_reset", 16'h3F81, 16'h3F81, 16'h3F82, F_NORM, X_INX, 11, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
